// File: rtl/signed_seq_divider.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per cycle, then a sign-correction cycle before done.
module signed_seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          dbz_q, dbz_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          div_by_zero_q, div_by_zero_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N:0]    shifted;
    logic [N:0]    trial;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        r_d           = r_q;
        q_d           = q_q;
        d_d           = d_q;
        qneg_d        = qneg_q;
        rneg_d        = rneg_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        busy_d        = busy_q;
        done_d        = done_q;
        // Partial remainder stays below |divisor|, so the shifted value fits N+1 bits
        // and its MSB is always clear; trial[N] is the borrow of the subtraction.
        shifted       = {r_q, q_q[N-1]};
        trial         = shifted - {1'b0, d_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = CW'(N - 1);
                    r_d     = '0;
                    q_d     = dividend[N-1] ? -dividend : dividend;
                    d_d     = divisor[N-1] ? -divisor : divisor;
                    qneg_d  = dividend[N-1] ^ divisor[N-1];
                    rneg_d  = dividend[N-1];
                    dbz_d   = (divisor == '0);
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                if (trial[N]) begin
                    r_d = shifted[N-1:0];
                    q_d = {q_q[N-2:0], 1'b0};
                end else begin
                    r_d = trial[N-1:0];
                    q_d = {q_q[N-2:0], 1'b1};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                // With a zero divisor every trial succeeds, leaving R = |dividend|.
                quotient_d    = dbz_q ? '1 : (qneg_q ? -q_q : q_q);
                remainder_d   = rneg_q ? -r_q : r_q;
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            r_q           <= '0;
            q_q           <= '0;
            d_q           <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            r_q           <= r_d;
            q_q           <= q_d;
            d_q           <= d_d;
            qneg_q        <= qneg_d;
            rneg_q        <= rneg_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Bench for signed_seq_divider: directed sign/edge/zero cases, handshake, hold and
// reset behaviour, plus random operands at N=8 and N=32 against a truncating-division model.
module tb_signed_seq_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  q8, r8;
    logic        busy8, done8, dbz8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] q32, r32;
    logic        busy32, done32, dbz32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    signed_seq_divider #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    signed_seq_divider #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .dividend(a32), .divisor(b32),
        .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: truncating division with plain 64-bit signed arithmetic.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dbz);
        longint sa, sb, mask;
        mask = (w == 8) ? 64'hFF : 64'hFFFF_FFFF;
        sa = (w == 8) ? longint'($signed(a[7:0])) : longint'($signed(a));
        sb = (w == 8) ? longint'($signed(b[7:0])) : longint'($signed(b));
        if (sb == 0) begin
            q   = 32'(mask);
            r   = 32'(sa & mask);
            dbz = 1'b1;
        end else begin
            q   = 32'((sa / sb) & mask);
            r   = 32'((sa % sb) & mask);
            dbz = 1'b0;
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge raising done.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dbz, output int lat);
        logic d;
        lat = 0;
        if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
        else        begin a32 = a;     b32 = b;     start32 = 1'b1; end
        do begin
            @(posedge clk); #1;
            start8  = 1'b0;
            start32 = 1'b0;
            lat++;
            d = (w == 8) ? done8 : done32;
        end while (!d && lat < 200);
        if (!d) check_val("done_timeout", 64'(lat), 64'(w + 2));
        q   = (w == 8) ? {24'b0, q8} : q32;
        r   = (w == 8) ? {24'b0, r8} : r32;
        dbz = (w == 8) ? dbz8 : dbz32;
    endtask

    task automatic op_and_check(input int w, input logic [31:0] a, input logic [31:0] b,
                                input string tag);
        logic [31:0] q, r, eq, er;
        logic        z, ez;
        int          lat;
        model(w, a, b, eq, er, ez);
        run_op(w, a, b, q, r, z, lat);
        check_val({tag, "_quot"}, 64'(q), 64'(eq));
        check_val({tag, "_rem"},  64'(r), 64'(er));
        check_val({tag, "_dbz"},  64'(z), 64'(ez));
        check_val({tag, "_lat"},  64'(lat), 64'(w + 2));
        @(posedge clk); #1;
        check_val({tag, "_done_fall"}, 64'((w == 8) ? done8 : done32), 64'(0));
        check_val({tag, "_busy_fall"}, 64'((w == 8) ? busy8 : busy32), 64'(0));
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = (w == 8) ? 32'h80 : 32'h8000_0000;
            4:       v = (w == 8) ? 32'h7F : 32'h7FFF_FFFF;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    logic [7:0] da [10] = '{8'h07, 8'hF9, 8'h07, 8'hF9, 8'h80, 8'h80, 8'h03, 8'h00, 8'h05, 8'hFB};
    logic [7:0] db [10] = '{8'h02, 8'h02, 8'hFE, 8'hFE, 8'hFF, 8'h01, 8'h64, 8'hFB, 8'h00, 8'h00};
    logic [7:0] dq [10] = '{8'h03, 8'hFD, 8'hFD, 8'h03, 8'h80, 8'h80, 8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] dr [10] = '{8'h01, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h03, 8'h00, 8'h05, 8'hFB};
    logic       dz [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [31:0] q, r;
        logic        z;
        int          lat, ndone;

        #12;
        check_val("rst_quot", 64'(q8), 64'(0));
        check_val("rst_rem",  64'(r8), 64'(0));
        check_val("rst_ctl",  64'({busy8, done8, dbz8}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(8, {24'b0, da[i]}, {24'b0, db[i]}, q, r, z, lat);
            check_val($sformatf("dir%0d_quot", i), 64'(q), 64'(dq[i]));
            check_val($sformatf("dir%0d_rem", i),  64'(r), 64'(dr[i]));
            check_val($sformatf("dir%0d_dbz", i),  64'(z), 64'(dz[i]));
            check_val($sformatf("dir%0d_lat", i),  64'(lat), 64'(10));
            @(posedge clk); #1;
        end

        // 20/3 with extra start pulses during CALC (edge 4) and DONE (edge 10).
        ndone = 0;
        a8 = 8'd20; b8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) ndone++;
            if (k == 3) begin a8 = 8'd100; b8 = 8'd7; start8 = 1'b1; end
            if (k == 9) begin
                check_val("hs_done_at_n1", 64'(done8), 64'(1));
                a8 = 8'hCE; b8 = 8'd3; start8 = 1'b1;
            end
        end
        check_val("hs_done_count", 64'(ndone), 64'(1));
        check_val("hs_quot", 64'(q8), 64'(6));
        check_val("hs_rem",  64'(r8), 64'(2));
        check_val("hs_busy", 64'(busy8), 64'(0));

        // Outputs keep the old result until the next FIXUP edge.
        a8 = 8'h9C; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 8) begin
                check_val("hold_quot", 64'(q8), 64'(6));
                check_val("hold_rem",  64'(r8), 64'(2));
            end
        end
        check_val("hold_new_quot", 64'(q8), 64'(8'hF2));
        check_val("hold_new_rem",  64'(r8), 64'(8'hFE));
        @(posedge clk); #1;

        // Reset in the middle of CALC.
        a8 = 8'd77; b8 = 8'd5; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("midrst_quot", 64'(q8), 64'(0));
        check_val("midrst_rem",  64'(r8), 64'(0));
        check_val("midrst_ctl",  64'({busy8, done8, dbz8}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) ndone++;
        end
        check_val("midrst_no_done", 64'(ndone), 64'(0));
        run_op(8, 32'd100, 32'd7, q, r, z, lat);
        check_val("postrst_quot", 64'(q), 64'(14));
        check_val("postrst_rem",  64'(r), 64'(2));
        check_val("postrst_lat",  64'(lat), 64'(10));
        @(posedge clk); #1;

        op_and_check(32, 32'h8000_0000, 32'hFFFF_FFFF, "w32_minneg");
        op_and_check(32, 32'hFFFF_FFF9, 32'h0000_0000, "w32_dbz");
        op_and_check(32, 32'h7FFF_FFFF, 32'h8000_0000, "w32_small");

        for (int i = 0; i < 1200; i++) op_and_check(8, pick(8), pick(8), "rnd8");
        for (int i = 0; i < 800; i++)  op_and_check(32, pick(32), pick(32), "rnd32");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
